red_pitaya_na_sweep_ctrl: RTL

Network-analyzer sweep sequencer that masters the IQ block's register bus. For each of N points it:
- writes the frequency word to 0x108, which restarts IQ averaging;
- polls the averaging flag;
- reads back the two 62-bit quadrature sums;
- presents frequency plus sums on a valid/ready result port.
Sits between the PS-side NA configuration registers and one IQ block instance.

---
 rtl/red_pitaya_na_sweep_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_na_sweep_ctrl.sv
// Network-analyzer sweep sequencer.
// Masters the IQ block register bus: for every sweep point it writes the
// frequency word (which restarts averaging), polls the averaging flag until
// it clears, reads the two 62-bit quadrature sums and hands the point out on
// a valid/ready result port.
module red_pitaya_na_sweep_ctrl #(
  parameter int PHASEBITS  = 32,
  parameter int POINTBITS  = 16,
  parameter int POLLDLY    = 8,
  parameter int ACKTIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [PHASEBITS-1:0] f_start_i,
  input  logic [PHASEBITS-1:0] f_step_i,
  input  logic [POINTBITS-1:0] n_points_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [15:0]          m_addr_o,
  output logic                 m_wen_o,
  output logic                 m_ren_o,
  output logic [31:0]          m_wdata_o,
  input  logic                 m_ack_i,
  input  logic [31:0]          m_rdata_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [PHASEBITS-1:0] res_freq_o,
  output logic [POINTBITS-1:0] res_idx_o,
  output logic [61:0]          res_i_o,
  output logic [61:0]          res_q_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_FREQ = 3'd1;
  localparam logic [2:0] ST_POLL    = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RD_IH   = 3'd4;
  localparam logic [2:0] ST_RD_QL   = 3'd5;
  localparam logic [2:0] ST_RD_QH   = 3'd6;
  localparam logic [2:0] ST_OUT     = 3'd7;

  localparam logic [15:0] ADDR_FREQ = 16'h0108;
  localparam logic [15:0] ADDR_STAT = 16'h0140;
  localparam logic [15:0] ADDR_IH   = 16'h0144;
  localparam logic [15:0] ADDR_QL   = 16'h0148;
  localparam logic [15:0] ADDR_QH   = 16'h014C;

  localparam int TW = (ACKTIMEOUT < 2) ? 1 : $clog2(ACKTIMEOUT + 1);
  localparam int WW = (POLLDLY < 2) ? 1 : $clog2(POLLDLY + 1);

  localparam logic [TW-1:0]        TO_LIM    = TW'(ACKTIMEOUT);
  localparam logic [TW-1:0]        TO_ONE    = TW'(1);
  localparam logic [WW-1:0]        WAIT_LAST = WW'(POLLDLY - 1);
  localparam logic [WW-1:0]        WAIT_ONE  = WW'(1);
  localparam logic [POINTBITS-1:0] IDX_ONE   = POINTBITS'(1);

  logic [2:0]           state_r;
  logic [2:0]           ack_next_s;
  logic                 issued_r;   // strobe of the current bus state already sent
  logic [TW-1:0]        tcnt_r;     // cycles elapsed since the last strobe
  logic [WW-1:0]        wcnt_r;     // idle cycles spent between polls
  logic [PHASEBITS-1:0] freq_r;
  logic [PHASEBITS-1:0] step_r;
  logic [POINTBITS-1:0] n_r;
  logic [POINTBITS-1:0] idx_r;
  logic [30:0]          lo_i_r;
  logic [30:0]          hi_i_r;
  logic [30:0]          lo_q_r;

  // Read address belonging to each read state of the sequence.
  function automatic logic [15:0] rd_addr(input logic [2:0] st);
    logic [15:0] a;
    case (st)
      ST_POLL:  a = ADDR_STAT;
      ST_RD_IH: a = ADDR_IH;
      ST_RD_QL: a = ADDR_QL;
      ST_RD_QH: a = ADDR_QH;
      default:  a = ADDR_STAT;
    endcase
    return a;
  endfunction

  // State to enter once the outstanding bus transaction is acknowledged.
  always_comb begin
    ack_next_s = ST_IDLE;
    case (state_r)
      ST_WR_FREQ: ack_next_s = ST_POLL;
      ST_POLL: begin
        if (m_rdata_i[31]) begin
          ack_next_s = ST_WAIT;
        end else begin
          ack_next_s = ST_RD_IH;
        end
      end
      ST_RD_IH: ack_next_s = ST_RD_QL;
      ST_RD_QL: ack_next_s = ST_RD_QH;
      ST_RD_QH: ack_next_s = ST_OUT;
      default:  ack_next_s = ST_IDLE;
    endcase
  end

  // Sweep sequencer: state, bus master, result port and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      issued_r    <= 1'b0;
      tcnt_r      <= '0;
      wcnt_r      <= '0;
      freq_r      <= '0;
      step_r      <= '0;
      n_r         <= '0;
      idx_r       <= '0;
      lo_i_r      <= 31'd0;
      hi_i_r      <= 31'd0;
      lo_q_r      <= 31'd0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      m_addr_o    <= 16'd0;
      m_wen_o     <= 1'b0;
      m_ren_o     <= 1'b0;
      m_wdata_o   <= 32'd0;
      res_valid_o <= 1'b0;
      res_freq_o  <= '0;
      res_idx_o   <= '0;
      res_i_o     <= 62'd0;
      res_q_o     <= 62'd0;
    end else begin
      // strobes and done are single-cycle pulses
      m_wen_o <= 1'b0;
      m_ren_o <= 1'b0;
      done_o  <= 1'b0;
      if (abort_i && (state_r != ST_IDLE)) begin
        state_r     <= ST_IDLE;
        issued_r    <= 1'b0;
        busy_o      <= 1'b0;
        res_valid_o <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start_i && !abort_i) begin
              error_o <= 1'b0;
              if (n_points_i == '0) begin
                done_o <= 1'b1;
              end else begin
                freq_r   <= f_start_i;
                step_r   <= f_step_i;
                n_r      <= n_points_i;
                idx_r    <= '0;
                busy_o   <= 1'b1;
                issued_r <= 1'b0;
                state_r  <= ST_WR_FREQ;
              end
            end
          end

          ST_WR_FREQ, ST_POLL, ST_RD_IH, ST_RD_QL, ST_RD_QH: begin
            if (!issued_r) begin
              // first frequency write of a sweep goes out one cycle after busy rises
              m_wen_o   <= 1'b1;
              m_addr_o  <= ADDR_FREQ;
              m_wdata_o <= 32'(freq_r);
              issued_r  <= 1'b1;
              tcnt_r    <= '0;
            end else if (m_ack_i) begin
              case (state_r)
                ST_POLL:  lo_i_r <= m_rdata_i[30:0];
                ST_RD_IH: hi_i_r <= m_rdata_i[30:0];
                ST_RD_QL: lo_q_r <= m_rdata_i[30:0];
                ST_RD_QH: begin
                  res_i_o <= {hi_i_r, lo_i_r};
                  res_q_o <= {m_rdata_i[30:0], lo_q_r};
                end
                default: lo_i_r <= lo_i_r;
              endcase
              state_r <= ack_next_s;
              if (ack_next_s == ST_WAIT) begin
                wcnt_r   <= '0;
                issued_r <= 1'b0;
              end else if (ack_next_s == ST_OUT) begin
                res_valid_o <= 1'b1;
                res_freq_o  <= freq_r;
                res_idx_o   <= idx_r;
                issued_r    <= 1'b0;
              end else begin
                // chain straight into the next read so each transaction takes two cycles
                m_ren_o  <= 1'b1;
                m_addr_o <= rd_addr(ack_next_s);
                issued_r <= 1'b1;
                tcnt_r   <= '0;
              end
            end else if (tcnt_r == TO_LIM) begin
              error_o  <= 1'b1;
              busy_o   <= 1'b0;
              issued_r <= 1'b0;
              state_r  <= ST_IDLE;
            end else begin
              tcnt_r <= tcnt_r + TO_ONE;
            end
          end

          ST_WAIT: begin
            if (wcnt_r == WAIT_LAST) begin
              m_ren_o  <= 1'b1;
              m_addr_o <= ADDR_STAT;
              issued_r <= 1'b1;
              tcnt_r   <= '0;
              state_r  <= ST_POLL;
            end else begin
              wcnt_r <= wcnt_r + WAIT_ONE;
            end
          end

          ST_OUT: begin
            if (res_ready_i) begin
              res_valid_o <= 1'b0;
              if (idx_r == (n_r - IDX_ONE)) begin
                done_o  <= 1'b1;
                busy_o  <= 1'b0;
                state_r <= ST_IDLE;
              end else begin
                idx_r     <= idx_r + IDX_ONE;
                freq_r    <= freq_r + step_r;
                m_wen_o   <= 1'b1;
                m_addr_o  <= ADDR_FREQ;
                m_wdata_o <= 32'(freq_r + step_r);
                issued_r  <= 1'b1;
                tcnt_r    <= '0;
                state_r   <= ST_WR_FREQ;
              end
            end
          end

          default: begin
            state_r  <= ST_IDLE;
            issued_r <= 1'b0;
            busy_o   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
